car_collision_checker: RTL and testbench

Per-frame collision checker that consumes the six car X positions produced by the obstacle movement block and tests them against the frog position. On each frame-start pulse it snapshots all positions, scans the cars one per clock and reports a registered hit pulse with the index of the lowest-numbered colliding car. The game controller uses the result to lose a life. A grace counter suppresses re-detection for a configurable number of frames after a hit.

---
 rtl/car_collision_checker_pkg.sv | 20 ++
 rtl/car_collision_checker_tile_overlap.sv | 24 ++
 rtl/car_collision_checker.sv | 128 ++++++++++++
 tb/tb_car_collision_checker.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/car_collision_checker_pkg.sv
// Shared game constants and scan-FSM state encoding for the frog/car collision logic.
package car_collision_checker_pkg;

  localparam int TILE_SIZE      = 32;
  localparam int H_VISIBLE_AREA = 640;
  localparam int FIRST_LANE_ROW = 2;
  localparam int NUM_CARS       = 6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  // Top pixel row of the lane that car `idx` drives on.
  function automatic logic [9:0] lane_y(input logic [2:0] idx);
    int y;
    y = (FIRST_LANE_ROW + int'(idx)) * TILE_SIZE;
    return 10'(y);
  endfunction

endpackage

// File: rtl/car_collision_checker_tile_overlap.sv
// Combinational lane match plus X-overlap test of two TILE_SIZE-wide sprites.
module tile_overlap #(
  parameter int TILE_SIZE = 32
) (
  input  logic [9:0] frog_x,
  input  logic [9:0] frog_y,
  input  logic [9:0] obj_x,
  input  logic [9:0] obj_y,
  output logic       hit
);

  logic [10:0] fx;
  logic [10:0] ox;
  logic [10:0] tile;

  // One extra bit so x + TILE_SIZE near the right screen edge cannot wrap.
  assign fx   = {1'b0, frog_x};
  assign ox   = {1'b0, obj_x};
  assign tile = 11'(TILE_SIZE);

  // Strict compares: sprites whose edges merely touch do not overlap.
  assign hit = (frog_y == obj_y) && (fx < ox + tile) && (ox < fx + tile);

endmodule

// File: rtl/car_collision_checker.sv
// Per-frame frog/car collision scan: snapshot on frame start, one car per clock, registered report.
module car_collision_checker
  import car_collision_checker_pkg::*;
#(
  parameter int GRACE_FRAMES = 60
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Frame_Start,
  input  logic [9:0] i_Frog_X,
  input  logic [9:0] i_Frog_Y,
  input  logic [9:0] i_Car_X_0,
  input  logic [9:0] i_Car_X_1,
  input  logic [9:0] i_Car_X_2,
  input  logic [9:0] i_Car_X_3,
  input  logic [9:0] i_Car_X_4,
  input  logic [9:0] i_Car_X_5,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Collision,
  output logic [2:0] o_Car_Index
);

  localparam logic [7:0] GRACE_INIT = 8'(GRACE_FRAMES);
  localparam logic [2:0] LAST_IDX   = 3'(NUM_CARS - 1);

  logic [1:0] state;
  logic [2:0] idx;
  logic [2:0] hit_idx;
  logic       hit;
  logic [7:0] grace;
  logic [9:0] snap_frog_x;
  logic [9:0] snap_frog_y;
  logic [9:0] snap_car [NUM_CARS];
  logic [9:0] sel_car_x;
  logic [9:0] sel_lane_y;
  logic       car_hit;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    sel_car_x = '0;
    case (idx)
      3'd0:    sel_car_x = snap_car[0];
      3'd1:    sel_car_x = snap_car[1];
      3'd2:    sel_car_x = snap_car[2];
      3'd3:    sel_car_x = snap_car[3];
      3'd4:    sel_car_x = snap_car[4];
      3'd5:    sel_car_x = snap_car[5];
      default: sel_car_x = '0;
    endcase
  end

  assign sel_lane_y = lane_y(idx);

  tile_overlap #(
    .TILE_SIZE(TILE_SIZE)
  ) u_overlap (
    .frog_x(snap_frog_x),
    .frog_y(snap_frog_y),
    .obj_x (sel_car_x),
    .obj_y (sel_lane_y),
    .hit   (car_hit)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      hit         <= 1'b0;
      hit_idx     <= '0;
      grace       <= '0;
      snap_frog_x <= '0;
      snap_frog_y <= '0;
      // NOTE: the snapshot bank is small and must read as zero after reset, so it is cleared here.
      for (int k = 0; k < NUM_CARS; k++) snap_car[k] <= '0;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
      o_Collision <= 1'b0;
      o_Car_Index <= '0;
    end else begin
      o_Done      <= 1'b0;
      o_Collision <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_Frame_Start) begin
            if (grace == 8'd0) begin
              snap_frog_x <= i_Frog_X;
              snap_frog_y <= i_Frog_Y;
              snap_car[0] <= i_Car_X_0;
              snap_car[1] <= i_Car_X_1;
              snap_car[2] <= i_Car_X_2;
              snap_car[3] <= i_Car_X_3;
              snap_car[4] <= i_Car_X_4;
              snap_car[5] <= i_Car_X_5;
              idx         <= '0;
              hit         <= 1'b0;
              hit_idx     <= '0;
              o_Busy      <= 1'b1;
              state       <= ST_SCAN;
            end else begin
              grace <= grace - 8'd1;
            end
          end
        end
        ST_SCAN: begin
          // First hit wins; later cars never overwrite the stored index.
          if (car_hit && !hit) begin
            hit     <= 1'b1;
            hit_idx <= idx;
          end
          if (idx == LAST_IDX) state <= ST_REPORT;
          else                 idx   <= idx + 3'd1;
        end
        ST_REPORT: begin
          o_Done      <= 1'b1;
          o_Collision <= hit;
          o_Car_Index <= hit_idx;
          o_Busy      <= 1'b0;
          if (hit) grace <= GRACE_INIT;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_car_collision_checker.sv
// Self-checking bench: directed scenarios plus randomized frames against a behavioural model.
module tb_car_collision_checker;

  localparam int GRACE = 2;
  localparam int TILE  = 32;
  localparam int ROW0  = 2;

  logic       i_Clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Frame_Start = 1'b0;
  logic [9:0] i_Frog_X = '0;
  logic [9:0] i_Frog_Y = '0;
  logic [9:0] car_x [6];
  logic       o_Busy;
  logic       o_Done;
  logic       o_Collision;
  logic [2:0] o_Car_Index;

  int compared   = 0;
  int mismatched = 0;
  int m_grace    = 0;

  always #5 i_Clk = ~i_Clk;

  car_collision_checker #(
    .GRACE_FRAMES(GRACE)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Frame_Start(i_Frame_Start),
    .i_Frog_X     (i_Frog_X),
    .i_Frog_Y     (i_Frog_Y),
    .i_Car_X_0    (car_x[0]),
    .i_Car_X_1    (car_x[1]),
    .i_Car_X_2    (car_x[2]),
    .i_Car_X_3    (car_x[3]),
    .i_Car_X_4    (car_x[4]),
    .i_Car_X_5    (car_x[5]),
    .o_Busy       (o_Busy),
    .o_Done       (o_Done),
    .o_Collision  (o_Collision),
    .o_Car_Index  (o_Car_Index)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: lowest car whose lane equals the frog row and whose box strictly overlaps.
  function automatic void ref_model(output bit h, output int ix);
    int fx, fy, cx;
    h  = 1'b0;
    ix = 0;
    fx = int'(i_Frog_X);
    fy = int'(i_Frog_Y);
    for (int k = 0; k < 6; k++) begin
      cx = int'(car_x[k]);
      if (!h && fy == (ROW0 + k) * TILE && fx < cx + TILE && cx < fx + TILE) begin
        h  = 1'b1;
        ix = k;
      end
    end
  endfunction

  task automatic set_scene(input int fx, input int fy, input int c0, input int c1,
                           input int c2, input int c3, input int c4, input int c5);
    i_Frog_X = 10'(fx);
    i_Frog_Y = 10'(fy);
    car_x[0] = 10'(c0); car_x[1] = 10'(c1); car_x[2] = 10'(c2);
    car_x[3] = 10'(c3); car_x[4] = 10'(c4); car_x[5] = 10'(c5);
  endtask

  task automatic random_scene();
    int fx, c;
    fx = $urandom_range(0, 639);
    i_Frog_X = 10'(fx);
    i_Frog_Y = 10'($urandom_range(1, 9) * TILE);
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        c = fx - 40 + int'($urandom_range(0, 80));
        if (c < 0) c = 0;
        if (c > 639) c = 639;
      end else begin
        c = $urandom_range(0, 639);
      end
      car_x[k] = 10'(c);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(o_Busy), 32'd0);
    check({tag, "_done"}, 32'(o_Done), 32'd0);
    check({tag, "_coll"}, 32'(o_Collision), 32'd0);
    check({tag, "_idx"},  32'(o_Car_Index), 32'd0);
  endtask

  task automatic reset_dut();
    @(negedge i_Clk);
    #2 i_Reset = 1'b1;
    #1 check_reset_outputs("rst");
    @(negedge i_Clk);
    i_Reset = 1'b0;
    m_grace = 0;
  endtask

  // One frame pulse; the model decides whether it scans or is swallowed by grace.
  task automatic run_frame(input string tag, input bit disturb);
    bit exp_hit, busy_ok, early_done, seen;
    int exp_idx;
    ref_model(exp_hit, exp_idx);
    @(negedge i_Clk);
    i_Frame_Start = 1'b1;
    @(negedge i_Clk);
    i_Frame_Start = 1'b0;
    if (m_grace == 0) begin
      busy_ok    = 1'b1;
      early_done = 1'b0;
      for (int c = 0; c < 7; c++) begin
        if (c > 0) @(negedge i_Clk);
        if (o_Busy !== 1'b1) busy_ok = 1'b0;
        if (o_Done !== 1'b0) early_done = 1'b1;
        if (disturb && c == 0) random_scene();
        if (disturb && (c == 2 || c == 6)) i_Frame_Start = 1'b1;
        if (disturb && c == 3) i_Frame_Start = 1'b0;
      end
      check({tag, "_busy_during_scan"}, 32'(busy_ok), 32'd1);
      check({tag, "_no_early_done"}, 32'(early_done), 32'd0);
      @(negedge i_Clk);
      i_Frame_Start = 1'b0;
      check({tag, "_done"}, 32'(o_Done), 32'd1);
      check({tag, "_coll"}, 32'(o_Collision), 32'(exp_hit));
      check({tag, "_busy_at_done"}, 32'(o_Busy), 32'd0);
      if (exp_hit) check({tag, "_idx"}, 32'(o_Car_Index), 32'(exp_idx));
      @(negedge i_Clk);
      check({tag, "_done_cleared"}, 32'(o_Done), 32'd0);
      if (exp_hit) m_grace = GRACE;
    end else begin
      m_grace--;
      seen = 1'b0;
      for (int c = 0; c < 18; c++) begin
        if (c > 0) @(negedge i_Clk);
        if (o_Done !== 1'b0 || o_Busy !== 1'b0) seen = 1'b1;
      end
      check({tag, "_grace_skip"}, 32'(seen), 32'd0);
    end
  endtask

  initial begin
    bit seen;
    set_scene(0, 0, 600, 600, 600, 600, 600, 600);
    #1 check_reset_outputs("por");
    @(negedge i_Clk);
    i_Reset = 1'b0;

    set_scene(100, 64, 120, 600, 600, 600, 600, 600);
    run_frame("basic_hit", 1'b0);
    reset_dut();

    set_scene(100, 96, 600, 68, 600, 600, 600, 600);
    run_frame("touch_edge", 1'b0);

    set_scene(100, 64, 100, 600, 600, 100, 600, 600);
    run_frame("lane_row2", 1'b0);
    reset_dut();

    set_scene(100, 160, 600, 600, 600, 100, 100, 600);
    run_frame("lane_row5", 1'b0);
    run_frame("drain_g1", 1'b0);
    run_frame("drain_g2", 1'b0);

    // Mid-scan reset: outputs clear asynchronously and the aborted scan never reports.
    set_scene(100, 64, 120, 600, 600, 600, 600, 600);
    @(negedge i_Clk);
    i_Frame_Start = 1'b1;
    @(negedge i_Clk);
    i_Frame_Start = 1'b0;
    @(negedge i_Clk);
    @(negedge i_Clk);
    check("midrst_busy_before", 32'(o_Busy), 32'd1);
    #2 i_Reset = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge i_Clk);
    i_Reset = 1'b0;
    m_grace = 0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_Clk);
      if (o_Done !== 1'b0) seen = 1'b1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    run_frame("after_rst", 1'b0);

    run_frame("grace_p1", 1'b0);
    run_frame("grace_p2", 1'b0);
    run_frame("grace_p3", 1'b0);
    reset_dut();

    set_scene(0, 64, 620, 600, 600, 600, 600, 600);
    run_frame("no_wrap", 1'b0);
    set_scene(0, 64, 10, 600, 600, 600, 600, 600);
    run_frame("near_left", 1'b0);
    reset_dut();

    for (int n = 0; n < 60; n++) begin
      random_scene();
      run_frame("rand", 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
